// File: rtl/raster_draw_scheduler_pkg.sv
// Shared encodings and defaults for the raster draw scheduler.
package raster_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_HEIGHT = 3;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned NUM_REQ    = 2;

    typedef enum logic [1:0] {
        OP_DRAW   = 2'b00,
        OP_ERASE  = 2'b01,
        OP_INVERT = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

endpackage

// File: rtl/raster_draw_scheduler_if.sv
// Two-requester draw command bus; requester n occupies slice n of each field.
interface raster_draw_scheduler_if
    import raster_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*WIDTH-1:0]  req_ax;
    logic [NUM_REQ*WIDTH-1:0]  req_bx;
    logic [NUM_REQ*WIDTH-1:0]  req_cx;
    logic [NUM_REQ*HEIGHT-1:0] req_ay;
    logic [NUM_REQ*HEIGHT-1:0] req_by;
    logic [NUM_REQ*HEIGHT-1:0] req_cy;

    modport master (
        output req_valid, req_op, req_ax, req_bx, req_cx, req_ay, req_by, req_cy,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_ax, req_bx, req_cx, req_ay, req_by, req_cy,
        output req_ready
    );

endinterface

// File: rtl/raster_draw_scheduler_arb.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection and winner bookkeeping
    always_comb begin
        grant        = valid;
        last_grant_d = last_grant_q;
        if (valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
        if (advance) begin
            last_grant_d = grant[1];
        end
    end

    // Last winner; reset value lets requester 0 take the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/raster_draw_scheduler.sv
// Command front-end: arbitrates draw commands, drives the rasterizer, composites into fb.
module raster_draw_scheduler
    import raster_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    raster_draw_scheduler_if.slave    req,
    output logic [WIDTH-1:0]          rast_ax,
    output logic [HEIGHT-1:0]         rast_ay,
    output logic [WIDTH-1:0]          rast_bx,
    output logic [HEIGHT-1:0]         rast_by,
    output logic [WIDTH-1:0]          rast_cx,
    output logic [HEIGHT-1:0]         rast_cy,
    output logic                      rast_shape,
    input  logic [WIDTH*HEIGHT-1:0]   rast_screen,
    output logic [WIDTH*HEIGHT-1:0]   fb,
    output logic                      done,
    output logic                      done_id,
    output logic                      busy,
    output logic                      degen
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic                id_q, id_d;
    logic [WIDTH-1:0]    ax_q, ax_d, bx_q, bx_d, cx_q, cx_d;
    logic [HEIGHT-1:0]   ay_q, ay_d, by_q, by_d, cy_q, cy_d;
    logic [NPIX-1:0]     fb_q, fb_d;
    logic                done_q, done_d;
    logic                done_id_q, done_id_d;
    logic                busy_q, busy_d;
    logic                degen_q, degen_d;
    logic [1:0]          grant;
    logic                advance;
    logic                sel;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (req.req_valid),
        .advance (advance),
        .grant   (grant)
    );

    assign sel           = grant[1];
    assign req.req_ready = (state_q == ST_IDLE) ? grant : 2'b00;

    // Next-state, command capture and framebuffer compositing
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        ax_d      = ax_q;
        bx_d      = bx_q;
        cx_d      = cx_q;
        ay_d      = ay_q;
        by_d      = by_q;
        cy_d      = cy_q;
        fb_d      = fb_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        degen_d   = degen_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    advance = 1'b1;
                    id_d    = sel;
                    op_d    = op_e'(sel ? req.req_op[2*OP_W-1:OP_W] : req.req_op[OP_W-1:0]);
                    ax_d    = sel ? req.req_ax[2*WIDTH-1:WIDTH]   : req.req_ax[WIDTH-1:0];
                    bx_d    = sel ? req.req_bx[2*WIDTH-1:WIDTH]   : req.req_bx[WIDTH-1:0];
                    cx_d    = sel ? req.req_cx[2*WIDTH-1:WIDTH]   : req.req_cx[WIDTH-1:0];
                    ay_d    = sel ? req.req_ay[2*HEIGHT-1:HEIGHT] : req.req_ay[HEIGHT-1:0];
                    by_d    = sel ? req.req_by[2*HEIGHT-1:HEIGHT] : req.req_by[HEIGHT-1:0];
                    cy_d    = sel ? req.req_cy[2*HEIGHT-1:HEIGHT] : req.req_cy[HEIGHT-1:0];
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                done_d    = 1'b1;
                done_id_d = id_q;
                state_d   = ST_IDLE;
                if (op_q == OP_CLEAR) begin
                    fb_d = '0;
                end else if ((ax_q > bx_q) || (ay_q > cy_q)) begin
                    // Empty region: leave fb alone regardless of what the rasterizer reports
                    degen_d = 1'b1;
                end else begin
                    case (op_q)
                        OP_DRAW:   fb_d = fb_q | rast_screen;
                        OP_ERASE:  fb_d = fb_q & ~rast_screen;
                        OP_INVERT: fb_d = fb_q ^ rast_screen;
                        default:   fb_d = fb_q;
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_DRAW;
            id_q      <= 1'b0;
            ax_q      <= '0;
            bx_q      <= '0;
            cx_q      <= '0;
            ay_q      <= '0;
            by_q      <= '0;
            cy_q      <= '0;
            fb_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
            degen_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            id_q      <= id_d;
            ax_q      <= ax_d;
            bx_q      <= bx_d;
            cx_q      <= cx_d;
            ay_q      <= ay_d;
            by_q      <= by_d;
            cy_q      <= cy_d;
            fb_q      <= fb_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
            degen_q   <= degen_d;
        end
    end

    assign rast_ax    = ax_q;
    assign rast_bx    = bx_q;
    assign rast_cx    = cx_q;
    assign rast_ay    = ay_q;
    assign rast_by    = by_q;
    assign rast_cy    = cy_q;
    assign rast_shape = 1'b0;
    assign fb         = fb_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign busy       = busy_q;
    assign degen      = degen_q;

endmodule
